// File: rtl/decode_pipe_pkg.sv
// Shared opcode constants and extension helpers for the decode pipeline.
package decode_pipe_pkg;

    // Widest datapath the extension helpers support; callers truncate to XLEN.
    localparam int EXT_W = 128;

    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_FPU   = 6'b010001;
    localparam logic [5:0] OP_FLW   = 6'b110001;
    localparam logic [5:0] OP_FSW   = 6'b111001;
    localparam logic [5:0] OP_JREL  = 6'b110010;
    localparam logic [5:0] OP_FPEXT = 6'b111111;

    localparam logic [4:0] OP_BR_PFX  = 5'b00010; // beq/bne
    localparam logic [3:0] OP_LUI_PFX = 4'b0011;  // zero-extended immediate ops
    localparam logic [1:0] OP_MEM_PFX = 2'b10;    // integer loads and stores
    localparam logic [2:0] OP_ST_PFX  = 3'b101;   // integer stores

    function automatic logic [EXT_W-1:0] sext16(input logic [15:0] v);
        return {{(EXT_W-16){v[15]}}, v};
    endfunction

    function automatic logic [EXT_W-1:0] zext16(input logic [15:0] v);
        return {{(EXT_W-16){1'b0}}, v};
    endfunction

    function automatic logic [EXT_W-1:0] sext28(input logic [27:0] v);
        return {{(EXT_W-28){v[27]}}, v};
    endfunction

    function automatic logic [EXT_W-1:0] zext28(input logic [27:0] v);
        return {{(EXT_W-28){1'b0}}, v};
    endfunction

endpackage

// File: rtl/decode_pipe_fwd_mux.sv
// Operand resolution for one source: picks the youngest matching producer,
// flags a hazard when that producer has no data yet, else falls back to regfile.
module decode_fwd_mux #(
    parameter int NFWD = 2,
    parameter int XLEN = 32
) (
    input  logic [4:0]         addr,
    input  logic               fmode,
    input  logic [XLEN-1:0]    reg_data,
    input  logic [NFWD-1:0]    fwd_valid,
    input  logic [NFWD-1:0]    fwd_ready,
    input  logic [NFWD-1:0]    fwd_fp,
    input  logic [5*NFWD-1:0]  fwd_rd,
    input  logic [XLEN*NFWD-1:0] fwd_data,
    output logic [XLEN-1:0]    data,
    output logic               hazard
);

    logic found;

    // Lowest index wins; integer r0 is hardwired and never forwarded.
    always_comb begin
        data   = reg_data;
        hazard = 1'b0;
        found  = 1'b0;
        for (int i = 0; i < NFWD; i++) begin
            if (!found && fwd_valid[i] && (fwd_rd[i*5 +: 5] == addr) &&
                (fwd_fp[i] == fmode) && (fmode || (addr != 5'd0))) begin
                found  = 1'b1;
                hazard = !fwd_ready[i];
                data   = fwd_data[i*XLEN +: XLEN];
            end
        end
    end

endmodule

// File: rtl/decode_pipe.sv
// Two-stage decode: S1 holds the fetched instruction and reads operands,
// S2 is the output register toward exec. Stalls on unresolved producers.
module decode_pipe
    import decode_pipe_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NFWD  = 2,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_pc,
    input  logic [31:0]          in_cmd,
    input  logic                 flush,
    output logic [4:0]           reg1,
    output logic [4:0]           reg2,
    input  logic [XLEN-1:0]      reg_out1,
    input  logic [XLEN-1:0]      reg_out2,
    input  logic [NFWD-1:0]      fwd_valid,
    input  logic [NFWD-1:0]      fwd_ready,
    input  logic [NFWD-1:0]      fwd_fp,
    input  logic [5*NFWD-1:0]    fwd_rd,
    input  logic [XLEN*NFWD-1:0] fwd_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_pc,
    output logic [5:0]           out_op,
    output logic [5:0]           out_funct,
    output logic [4:0]           out_rd,
    output logic [4:0]           out_sh,
    output logic [XLEN-1:0]      out_rs,
    output logic [XLEN-1:0]      out_rt,
    output logic [XLEN-1:0]      out_addr,
    output logic                 out_fmode,
    output logic [CNT_W-1:0]     stall_cnt
);

    logic            s1_valid;
    logic [31:0]     s1_pc, s1_cmd;
    logic [5:0]      op;
    logic            fmode;
    logic [XLEN-1:0] src1, src2;
    logic            hz1, hz2, hazard, s1_adv;
    logic [XLEN-1:0] imm_s, imm_z, jt_z, jt_s;
    logic [XLEN-1:0] nx_rt, nx_addr;

    assign op    = s1_cmd[31:26];
    assign imm_s = XLEN'(sext16(s1_cmd[15:0]));
    assign imm_z = XLEN'(zext16(s1_cmd[15:0]));
    assign jt_z  = XLEN'(zext28({s1_cmd[25:0], 2'b00}));
    assign jt_s  = XLEN'(sext28({s1_cmd[25:0], 2'b00}));

    // Branches and stores read their second operand from the rd field.
    assign reg1  = s1_cmd[20:16];
    assign reg2  = ((op[5:1] == OP_BR_PFX) || (op[5:3] == OP_ST_PFX) || (op == OP_FSW))
                   ? s1_cmd[25:21] : s1_cmd[15:11];
    assign fmode = (op == OP_FPU) || (op == OP_FSW) || ((op == OP_FPEXT) && s1_cmd[1]);

    decode_fwd_mux #(.NFWD(NFWD), .XLEN(XLEN)) u_fwd1 (
        .addr(reg1), .fmode(fmode), .reg_data(reg_out1),
        .fwd_valid(fwd_valid), .fwd_ready(fwd_ready), .fwd_fp(fwd_fp),
        .fwd_rd(fwd_rd), .fwd_data(fwd_data), .data(src1), .hazard(hz1)
    );

    decode_fwd_mux #(.NFWD(NFWD), .XLEN(XLEN)) u_fwd2 (
        .addr(reg2), .fmode(fmode), .reg_data(reg_out2),
        .fwd_valid(fwd_valid), .fwd_ready(fwd_ready), .fwd_fp(fwd_fp),
        .fwd_rd(fwd_rd), .fwd_data(fwd_data), .data(src2), .hazard(hz2)
    );

    assign hazard   = hz1 | hz2;
    assign s1_adv   = s1_valid && !hazard && (!out_valid || out_ready);
    // Combinational through out_ready so a draining S2 keeps full throughput.
    assign in_ready = !flush && (!s1_valid || s1_adv);

    // Immediate substitution and address generation from the S1 opcode.
    always_comb begin
        nx_rt   = src2;
        nx_addr = '0;
        if ((op == OP_J) || (op == OP_JAL))
            nx_addr = jt_z;
        else if ((op == OP_BEQ) || (op == OP_BNE))
            nx_addr = imm_s << 2;
        else if (op == OP_ADDI)
            nx_rt = imm_s;
        else if (op[5:2] == OP_LUI_PFX)
            nx_rt = imm_z;
        else if ((op[5:4] == OP_MEM_PFX) || (op == OP_FLW) || (op == OP_FSW))
            nx_addr = src1 + imm_s;
        else if (op == OP_JREL)
            nx_addr = jt_s;
    end

    // S1: capture on handshake, empty when passed to S2 or flushed.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_valid <= 1'b0;
            s1_pc    <= '0;
            s1_cmd   <= '0;
        end else if (flush) begin
            s1_valid <= 1'b0;
        end else if (in_valid && in_ready) begin
            s1_valid <= 1'b1;
            s1_pc    <= in_pc;
            s1_cmd   <= in_cmd;
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    // S2: output register, held stable while exec back-pressures.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid <= 1'b0;
            out_pc    <= '0;
            out_op    <= '0;
            out_funct <= '0;
            out_rd    <= '0;
            out_sh    <= '0;
            out_rs    <= '0;
            out_rt    <= '0;
            out_addr  <= '0;
            out_fmode <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (s1_adv) begin
            out_valid <= 1'b1;
            out_pc    <= s1_pc;
            out_op    <= op;
            out_funct <= s1_cmd[5:0];
            out_rd    <= s1_cmd[25:21];
            out_sh    <= s1_cmd[10:6];
            out_rs    <= src1;
            out_rt    <= nx_rt;
            out_addr  <= nx_addr;
            out_fmode <= fmode;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Saturating count of cycles lost to unresolved producers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            stall_cnt <= '0;
        else if (s1_valid && hazard && !flush && (stall_cnt != {CNT_W{1'b1}}))
            stall_cnt <= stall_cnt + CNT_W'(1);
    end

endmodule

// File: tb/tb_decode_pipe.sv
// Directed bench for decode_pipe: queue-based reference model plus literal pins.
module tb_decode_pipe;

    localparam int XLEN  = 32;
    localparam int NFWD  = 2;
    localparam int CNT_W = 16;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    logic              in_valid, in_ready, flush;
    logic [31:0]       in_pc, in_cmd;
    logic [4:0]        reg1, reg2;
    logic [XLEN-1:0]   reg_out1, reg_out2;
    logic [NFWD-1:0]   fwd_valid, fwd_ready, fwd_fp;
    logic [5*NFWD-1:0] fwd_rd;
    logic [XLEN*NFWD-1:0] fwd_data;
    logic              out_valid, out_ready, out_fmode;
    logic [31:0]       out_pc;
    logic [5:0]        out_op, out_funct;
    logic [4:0]        out_rd, out_sh;
    logic [XLEN-1:0]   out_rs, out_rt, out_addr;
    logic [CNT_W-1:0]  stall_cnt;

    logic [XLEN-1:0] rf [32];
    assign reg_out1 = rf[reg1];
    assign reg_out2 = rf[reg2];

    logic bp_en, rnd_rdy, rdy_q;
    assign out_ready = bp_en ? rnd_rdy : rdy_q;

    decode_pipe #(.XLEN(XLEN), .NFWD(NFWD), .CNT_W(CNT_W)) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_cmd(in_cmd), .flush(flush), .reg1(reg1), .reg2(reg2),
        .reg_out1(reg_out1), .reg_out2(reg_out2), .fwd_valid(fwd_valid),
        .fwd_ready(fwd_ready), .fwd_fp(fwd_fp), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_op(out_op),
        .out_funct(out_funct), .out_rd(out_rd), .out_sh(out_sh), .out_rs(out_rs),
        .out_rt(out_rt), .out_addr(out_addr), .out_fmode(out_fmode), .stall_cnt(stall_cnt)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [5:0]  op;
        logic [5:0]  funct;
        logic [4:0]  rd;
        logic [4:0]  sh;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] addr;
        logic        fm;
    } exp_t;

    exp_t expq[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Operand value as the ISA defines it: the youngest matching producer's
    // result (whenever it arrives), else the register file.
    function automatic logic [31:0] resolve(input logic [4:0] a, input logic fm);
        for (int i = 0; i < NFWD; i++)
            if (fwd_valid[i] && fwd_rd[i*5 +: 5] == a && fwd_fp[i] == fm && (fm || a != 5'd0))
                return fwd_data[i*32 +: 32];
        return rf[a];
    endfunction

    function automatic exp_t model(input logic [31:0] pc, input logic [31:0] cmd);
        exp_t e;
        logic [5:0]  op = cmd[31:26];
        logic [31:0] se = {{16{cmd[15]}}, cmd[15:0]};
        logic [4:0]  a2;
        logic        fm;
        logic [31:0] rs, rt;
        fm = (op == 6'h11) || (op == 6'h39) || (op == 6'h3F && cmd[1]);
        a2 = (op == 6'h04 || op == 6'h05 || (op >= 6'h28 && op <= 6'h2F) || op == 6'h39)
             ? cmd[25:21] : cmd[15:11];
        rs = resolve(cmd[20:16], fm);
        rt = resolve(a2, fm);
        e.addr = 32'h0;
        case (op)
            6'h02, 6'h03:               e.addr = {4'b0, cmd[25:0], 2'b00};
            6'h04, 6'h05:               e.addr = se * 4;
            6'h08:                      rt = se;
            6'h0C, 6'h0D, 6'h0E, 6'h0F: rt = {16'h0, cmd[15:0]};
            6'h31, 6'h39:               e.addr = rs + se;
            6'h32:                      e.addr = {{4{cmd[25]}}, cmd[25:0], 2'b00};
            default: if (op >= 6'h20 && op <= 6'h2F) e.addr = rs + se;
        endcase
        e.pc = pc; e.op = op; e.funct = cmd[5:0]; e.rd = cmd[25:21]; e.sh = cmd[10:6];
        e.rs = rs; e.rt = rt; e.fm = fm;
        return e;
    endfunction

    // Every accepted instruction is expected to emerge, in order.
    always @(posedge clk)
        if (rstn && in_valid && in_ready) expq.push_back(model(in_pc, in_cmd));

    // Output checker: every valid cycle must match the oldest outstanding instruction.
    always @(negedge clk) begin : cmp_p
        exp_t act;
        if (rstn && out_valid) begin
            checks++;
            if (expq.size() == 0) begin
                errors++;
                $display("FAIL out_unexpected: got pc %h op %h, required no output", out_pc, out_op);
            end else begin
                act = {out_pc, out_op, out_funct, out_rd, out_sh, out_rs, out_rt, out_addr, out_fmode};
                if (act !== expq[0]) begin
                    errors++;
                    $display("FAIL out_compare: got %h required %h", act, expq[0]);
                end
                if (out_ready) void'(expq.pop_front());
            end
        end
    end

    always begin
        @(posedge clk);
        #1 rnd_rdy = 1'($urandom_range(0, 1));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] pc, input logic [31:0] cmd);
        bit ok = 1'b0;
        in_valid = 1'b1; in_pc = pc; in_cmd = cmd;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(posedge clk);
            ok = in_ready;
        end
        #1 in_valid = 1'b0;
        chk("send_accept", 64'(ok), 64'(1));
    endtask

    logic [31:0] stream [12] = '{32'h10220004, 32'h0C000100, 32'h44A51883, 32'hC4A50010,
                                 32'hE4A6FFF0, 32'hCBFFFFFF, 32'hFC000002, 32'hFC000000,
                                 32'hAC450004, 32'h3CC3ABCD, 32'h00000000, 32'h8C440008};

    initial begin
        rstn = 1'b0; in_valid = 1'b0; in_pc = '0; in_cmd = '0; flush = 1'b0;
        fwd_valid = '0; fwd_ready = '0; fwd_fp = '0; fwd_rd = '0; fwd_data = '0;
        bp_en = 1'b0; rdy_q = 1'b1; rnd_rdy = 1'b1;
        for (int i = 0; i < 32; i++) rf[i] = 32'h1000_0000 + i * 32'h101;
        rf[0] = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_stall_cnt", 64'(stall_cnt), 64'(0));
        chk("rst_out_addr", 64'(out_addr), 64'(0));
        rstn = 1'b1;
        #1 chk("rst_in_ready", 64'(in_ready), 64'(1));
        tick();

        // addi: two-cycle latency and sign-extended immediate
        rf[1] = 32'h10;
        in_valid = 1'b1; in_pc = 32'h100; in_cmd = 32'h2061FFFC;
        tick(); in_valid = 1'b0;
        chk("addi_reg1", 64'(reg1), 64'(1));
        chk("addi_lat_n1", 64'(out_valid), 64'(0));
        tick();
        chk("addi_lat_n2", 64'(out_valid), 64'(1));
        chk("addi_rs", 64'(out_rs), 64'(32'h10));
        chk("addi_rt", 64'(out_rt), 64'(32'hFFFFFFFC));
        chk("addi_rd", 64'(out_rd), 64'(3));
        tick();
        chk("addi_drop", 64'(out_valid), 64'(0));

        // load: effective address from regfile base
        rf[4] = 32'h1000;
        in_valid = 1'b1; in_pc = 32'h104; in_cmd = 32'h8C440008;
        tick(); in_valid = 1'b0;
        chk("ld_reg1", 64'(reg1), 64'(4));
        chk("ld_reg2", 64'(reg2), 64'(0));
        tick();
        chk("ld_addr", 64'(out_addr), 64'(32'h1008));
        tick();

        // hazard on youngest producer, older ready producer must be ignored
        fwd_valid = 2'b11; fwd_rd = {5'd4, 5'd4}; fwd_fp = 2'b00; fwd_ready = 2'b10;
        fwd_data = {32'h5555, 32'h2000};
        in_valid = 1'b1; in_pc = 32'h108; in_cmd = 32'h8C440008;
        tick(); in_valid = 1'b0;
        chk("hz_in_ready", 64'(in_ready), 64'(0));
        repeat (3) tick();
        chk("hz_stall_cnt", 64'(stall_cnt), 64'(3));
        chk("hz_held", 64'(out_valid), 64'(0));
        fwd_ready = 2'b11;
        tick();
        chk("hz_out_valid", 64'(out_valid), 64'(1));
        chk("hz_addr", 64'(out_addr), 64'(32'h2008));
        chk("hz_stall_final", 64'(stall_cnt), 64'(3));
        fwd_valid = 2'b00;
        tick();

        // back-pressure: two held, third refused until exec drains
        rdy_q = 1'b0;
        in_valid = 1'b1; in_pc = 32'h200; in_cmd = 32'h2061FFFC;
        tick(); in_pc = 32'h204; in_cmd = 32'h20A20005;
        tick(); in_pc = 32'h208; in_cmd = 32'h3CC3ABCD;
        chk("bp_in_ready_low", 64'(in_ready), 64'(0));
        tick(); tick();
        chk("bp_hold_valid", 64'(out_valid), 64'(1));
        chk("bp_hold_pc", 64'(out_pc), 64'(32'h200));
        chk("bp_still_low", 64'(in_ready), 64'(0));
        rdy_q = 1'b1;
        #1 chk("bp_in_ready_release", 64'(in_ready), 64'(1));
        tick(); in_valid = 1'b0;
        repeat (4) tick();
        chk("bp_drained", 64'(expq.size()), 64'(0));

        // jump target
        in_valid = 1'b1; in_pc = 32'h300; in_cmd = 32'h08000010;
        tick(); in_valid = 1'b0;
        tick();
        chk("j_addr", 64'(out_addr), 64'(32'h40));
        tick();

        // flush with S1 and S2 occupied: nothing survives
        rdy_q = 1'b0;
        in_valid = 1'b1; in_pc = 32'h400; in_cmd = 32'h2061FFFC;
        tick(); in_pc = 32'h404; in_cmd = 32'h20A20005;
        tick(); in_pc = 32'h408; in_cmd = 32'h3CC3ABCD;
        flush = 1'b1;
        #1 chk("flush_in_ready", 64'(in_ready), 64'(0));
        tick();
        flush = 1'b0; in_valid = 1'b0;
        expq.delete();
        chk("flush_out_valid", 64'(out_valid), 64'(0));
        rdy_q = 1'b1;
        repeat (4) tick();
        chk("flush_gone", 64'(out_valid), 64'(0));

        // mixed stream with random exec back-pressure and forwarding
        fwd_valid = 2'b11; fwd_rd = {5'd5, 5'd0}; fwd_fp = 2'b10; fwd_ready = 2'b11;
        fwd_data = {32'hF00DF00D, 32'hDEADBEEF};
        bp_en = 1'b1;
        for (int i = 0; i < 12; i++) send(32'h500 + 32'(i) * 4, stream[i]);
        for (int n = 0; n < 60 && (expq.size() != 0); n++) tick();
        chk("stream_drained", 64'(expq.size()), 64'(0));
        bp_en = 1'b0; fwd_valid = 2'b00;
        tick();

        // asynchronous reset mid-stream
        in_valid = 1'b1; in_pc = 32'h600; in_cmd = 32'h2061FFFC;
        tick(); in_pc = 32'h604;
        tick();
        #2 rstn = 1'b0;
        #1;
        chk("rst_mid_valid", 64'(out_valid), 64'(0));
        chk("rst_mid_stall", 64'(stall_cnt), 64'(0));
        expq.delete();
        in_valid = 1'b0;
        tick();
        rstn = 1'b1;
        #1 chk("rst_mid_in_ready", 64'(in_ready), 64'(1));
        repeat (3) tick();
        chk("rst_mid_quiet", 64'(out_valid), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
